// File: rtl/hm_cpl_responder.sv
// TRN-side target completer: answers 3DW Memory Read TLPs with CplD TLPs whose
// payload is read from a local 32-bit synchronous memory.
module hm_cpl_responder #(
    parameter int ADDR_W = 10,
    parameter int MAX_DW = 16
) (
    input  logic              trn_clk,
    input  logic              trn_reset_n,
    input  logic              trn_lnk_up_n,
    input  logic [63:0]       trn_rd,
    input  logic [7:0]        trn_rrem_n,
    input  logic              trn_rsof_n,
    input  logic              trn_reof_n,
    input  logic              trn_rsrc_rdy_n,
    input  logic              trn_rsrc_dsc_n,
    output logic              trn_rdst_rdy_n,
    output logic              trn_rnp_ok_n,
    output logic [63:0]       trn_td,
    output logic [7:0]        trn_trem_n,
    output logic              trn_tsof_n,
    output logic              trn_teof_n,
    output logic              trn_tsrc_rdy_n,
    output logic              trn_tsrc_dsc_n,
    input  logic              trn_tdst_rdy_n,
    input  logic [5:0]        trn_tbuf_av,
    input  logic [7:0]        cfg_bus_number,
    input  logic [4:0]        cfg_device_number,
    input  logic [2:0]        cfg_function_number,
    output logic [ADDR_W-1:0] mem_adr,
    input  logic [31:0]       mem_dat,
    output logic              cpl_done,
    output logic              err_drop
);

    // state   | meaning
    // IDLE    | wait for start of frame, decode header DW0/DW1
    // HDR2    | take header DW2 (request address)
    // DISCARD | drain the rest of an unsupported or rejected TLP
    // FETCH   | read length DWs from local memory into the buffer
    // TX_WAIT | wait for a free transmit buffer
    // TX      | stream the CplD beats
    typedef enum logic [2:0] {IDLE, HDR2, DISCARD, FETCH, TX_WAIT, TX} state_t;

    localparam int BW = (MAX_DW > 1) ? $clog2(MAX_DW) : 1;

    state_t       state;
    logic         active;
    logic [9:0]   len_q;
    logic [2:0]   tc_q;
    logic [1:0]   attr_q;
    logic [15:0]  rid_q;
    logic [7:0]   tag_q;
    logic [4:0]   lad_q;
    logic         drop_q;
    logic [9:0]   fcnt;
    logic [BW-1:0] wptr;
    logic [9:0]   bidx;
    logic [31:0]  dbuf [MAX_DW];

    logic         rx_state;
    logic         rx_take;
    logic [7:0]   rx_type;
    logic [9:0]   rx_len;
    logic         rx_ok;
    logic         rx_bad;
    logic         buf_we;
    logic [31:0]  hdr0;
    logic [31:0]  hdr1;
    logic [31:0]  hdr2;
    logic [9:0]   nb;
    logic [9:0]   nbeats;
    logic [9:0]   hi_idx;
    logic [9:0]   lo_idx;
    logic [63:0]  beat_nxt;
    logic         last_nxt;
    logic         unused_bits;

    // Byte enables, rem and reserved header bits play no part in a completion.
    assign unused_bits = ^{trn_rd, trn_rrem_n};

    assign rx_state       = (state == IDLE) || (state == HDR2) || (state == DISCARD);
    assign trn_rdst_rdy_n = ~(active & rx_state & ~trn_lnk_up_n);
    assign rx_take        = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
    assign trn_rnp_ok_n   = 1'b0;
    assign trn_tsrc_dsc_n = 1'b1;

    assign rx_type = trn_rd[63:56];
    assign rx_len  = trn_rd[41:32];
    assign rx_ok   = (rx_type == 8'h00) && (rx_len != 10'd0) && (rx_len <= 10'(MAX_DW));
    assign rx_bad  = ((rx_type == 8'h00) && !rx_ok) || (rx_type == 8'h20);

    assign hdr0   = {8'h4A, 1'b0, tc_q, 4'b0000, 2'b00, attr_q, 2'b00, len_q};
    assign hdr1   = {cfg_bus_number, cfg_device_number, cfg_function_number,
                     3'b000, 1'b0, len_q, 2'b00};
    assign hdr2   = {rid_q, tag_q, 1'b0, lad_q, 2'b00};
    assign nbeats = (len_q + 10'd4) >> 1;
    assign nb     = (state == TX) ? bidx + 10'd1 : 10'd0;
    assign buf_we = (state == FETCH) && (fcnt != 10'd0);

    // Beat k >= 2 carries buffer words 2k-3 (upper) and 2k-2 (lower).
    always_comb begin
        beat_nxt = 64'd0;
        hi_idx   = (nb << 1) - 10'd3;
        lo_idx   = (nb << 1) - 10'd2;
        if (nb == 10'd0) begin
            beat_nxt = {hdr0, hdr1};
        end else if (nb == 10'd1) begin
            beat_nxt = {hdr2, dbuf[0]};
        end else begin
            if (hi_idx < len_q) beat_nxt[63:32] = dbuf[hi_idx[BW-1:0]];
            if (lo_idx < len_q) beat_nxt[31:0]  = dbuf[lo_idx[BW-1:0]];
        end
        last_nxt = (nb == nbeats - 10'd1);
    end

    always_ff @(posedge trn_clk) begin
        if (buf_we) dbuf[wptr] <= mem_dat;
    end

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            state          <= IDLE;
            active         <= 1'b0;
            len_q          <= 10'd0;
            tc_q           <= 3'd0;
            attr_q         <= 2'd0;
            rid_q          <= 16'd0;
            tag_q          <= 8'd0;
            lad_q          <= 5'd0;
            drop_q         <= 1'b0;
            fcnt           <= 10'd0;
            wptr           <= '0;
            bidx           <= 10'd0;
            mem_adr        <= '0;
            trn_td         <= 64'd0;
            trn_trem_n     <= 8'd0;
            trn_tsof_n     <= 1'b1;
            trn_teof_n     <= 1'b1;
            trn_tsrc_rdy_n <= 1'b1;
            cpl_done       <= 1'b0;
            err_drop       <= 1'b0;
        end else begin
            active   <= 1'b1;
            cpl_done <= 1'b0;
            err_drop <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_take && !trn_rsrc_dsc_n) begin
                        err_drop <= 1'b1;
                    end else if (rx_take && !trn_rsof_n) begin
                        len_q  <= rx_len;
                        tc_q   <= trn_rd[54:52];
                        attr_q <= trn_rd[45:44];
                        rid_q  <= trn_rd[31:16];
                        tag_q  <= trn_rd[15:8];
                        drop_q <= rx_bad;
                        if (rx_ok)            state    <= HDR2;
                        else if (!trn_reof_n) err_drop <= rx_bad;
                        else                  state    <= DISCARD;
                    end
                end
                HDR2: begin
                    if (rx_take && !trn_rsrc_dsc_n) begin
                        err_drop <= 1'b1;
                        state    <= IDLE;
                    end else if (rx_take) begin
                        lad_q   <= trn_rd[38:34];
                        mem_adr <= trn_rd[ADDR_W+33:34];
                        fcnt    <= 10'd0;
                        wptr    <= '0;
                        state   <= FETCH;
                    end
                end
                DISCARD: begin
                    if (rx_take && !trn_rsrc_dsc_n) begin
                        err_drop <= 1'b1;
                        state    <= IDLE;
                    end else if (rx_take && !trn_reof_n) begin
                        err_drop <= drop_q;
                        state    <= IDLE;
                    end
                end
                FETCH: begin
                    if (fcnt < len_q) mem_adr <= mem_adr + 1'b1;
                    if (buf_we) wptr <= wptr + 1'b1;
                    if (fcnt == len_q) state <= TX_WAIT;
                    else               fcnt  <= fcnt + 10'd1;
                end
                TX_WAIT: begin
                    if (trn_tbuf_av != 6'd0) begin
                        state          <= TX;
                        bidx           <= 10'd0;
                        trn_td         <= beat_nxt;
                        trn_tsof_n     <= 1'b0;
                        trn_teof_n     <= ~last_nxt;
                        trn_trem_n     <= (last_nxt && !len_q[0]) ? 8'h0F : 8'h00;
                        trn_tsrc_rdy_n <= 1'b0;
                    end
                end
                TX: begin
                    if (!trn_tdst_rdy_n) begin
                        if (!trn_teof_n) begin
                            trn_td         <= 64'd0;
                            trn_trem_n     <= 8'd0;
                            trn_tsof_n     <= 1'b1;
                            trn_teof_n     <= 1'b1;
                            trn_tsrc_rdy_n <= 1'b1;
                            cpl_done       <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            bidx       <= nb;
                            trn_td     <= beat_nxt;
                            trn_tsof_n <= 1'b1;
                            trn_teof_n <= ~last_nxt;
                            trn_trem_n <= (last_nxt && !len_q[0]) ? 8'h0F : 8'h00;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hm_cpl_responder.sv
// Bench for hm_cpl_responder: directed cases plus randomized MRd traffic checked
// against a queue-based CplD model built from the request fields and memory image.
`timescale 1ns/1ps
module tb_hm_cpl_responder;
    localparam int ADDR_W = 10;
    localparam int MAX_DW = 16;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              trn_clk = 1'b0;
    logic              trn_reset_n;
    logic              trn_lnk_up_n;
    logic [63:0]       trn_rd;
    logic [7:0]        trn_rrem_n;
    logic              trn_rsof_n;
    logic              trn_reof_n;
    logic              trn_rsrc_rdy_n;
    logic              trn_rsrc_dsc_n;
    logic              trn_rdst_rdy_n;
    logic              trn_rnp_ok_n;
    logic [63:0]       trn_td;
    logic [7:0]        trn_trem_n;
    logic              trn_tsof_n;
    logic              trn_teof_n;
    logic              trn_tsrc_rdy_n;
    logic              trn_tsrc_dsc_n;
    logic              trn_tdst_rdy_n;
    logic [5:0]        trn_tbuf_av;
    logic [7:0]        cfg_bus_number;
    logic [4:0]        cfg_device_number;
    logic [2:0]        cfg_function_number;
    logic [ADDR_W-1:0] mem_adr;
    logic [31:0]       mem_dat;
    logic              cpl_done;
    logic              err_drop;

    typedef struct packed {
        logic [63:0] td;
        logic        sof;
        logic        eof;
        logic [7:0]  rem;
    } beat_t;

    beat_t       obs_q[$];
    beat_t       exp_q[$];
    logic [31:0] mem [DEPTH];
    int          n_chk = 0;
    int          n_err = 0;
    int          cpl_cnt = 0;
    int          err_cnt = 0;
    int          exp_cpl = 0;
    int          exp_err = 0;
    int          bp_mode = 0;
    logic        stall_v = 1'b0;
    logic [64:0] stall_val;

    hm_cpl_responder #(.ADDR_W(ADDR_W), .MAX_DW(MAX_DW)) dut (
        .trn_clk(trn_clk), .trn_reset_n(trn_reset_n), .trn_lnk_up_n(trn_lnk_up_n),
        .trn_rd(trn_rd), .trn_rrem_n(trn_rrem_n), .trn_rsof_n(trn_rsof_n),
        .trn_reof_n(trn_reof_n), .trn_rsrc_rdy_n(trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n(trn_rsrc_dsc_n), .trn_rdst_rdy_n(trn_rdst_rdy_n),
        .trn_rnp_ok_n(trn_rnp_ok_n), .trn_td(trn_td), .trn_trem_n(trn_trem_n),
        .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
        .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
        .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tbuf_av(trn_tbuf_av),
        .cfg_bus_number(cfg_bus_number), .cfg_device_number(cfg_device_number),
        .cfg_function_number(cfg_function_number), .mem_adr(mem_adr),
        .mem_dat(mem_dat), .cpl_done(cpl_done), .err_drop(err_drop)
    );

    always #5 trn_clk = ~trn_clk;

    always @(posedge trn_clk) mem_dat <= mem[mem_adr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Transmit-side monitor: a beat presented at the falling edge with the
    // sink ready is taken on the following rising edge.
    always @(negedge trn_clk) begin
        beat_t b;
        if (!trn_reset_n) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) chk("tx_hold", {trn_tsrc_rdy_n, trn_td}, stall_val);
            stall_v   = !trn_tsrc_rdy_n && trn_tdst_rdy_n;
            stall_val = {trn_tsrc_rdy_n, trn_td};
            if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
                b.td  = trn_td;
                b.sof = !trn_tsof_n;
                b.eof = !trn_teof_n;
                b.rem = trn_trem_n;
                obs_q.push_back(b);
            end
            if (cpl_done) cpl_cnt++;
            if (err_drop) err_cnt++;
        end
    end

    initial begin
        trn_tdst_rdy_n = 1'b0;
        forever begin
            @(posedge trn_clk);
            #1;
            case (bp_mode)
                0:       trn_tdst_rdy_n = 1'b0;
                1:       trn_tdst_rdy_n = ~trn_tdst_rdy_n;
                default: trn_tdst_rdy_n = ($urandom_range(0, 3) == 0);
            endcase
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [63:0] d, input logic sof, input logic eof,
                             input logic [7:0] rem, input logic dsc);
        int n;
        @(negedge trn_clk);
        trn_rd         = d;
        trn_rsof_n     = ~sof;
        trn_reof_n     = ~eof;
        trn_rrem_n     = rem;
        trn_rsrc_dsc_n = ~dsc;
        trn_rsrc_rdy_n = 1'b0;
        n = 0;
        while (trn_rdst_rdy_n && n < 400) begin
            @(negedge trn_clk);
            n++;
        end
        if (n >= 400) chk("rx_timeout", 1, 0);
    endtask

    task automatic rx_idle();
        @(negedge trn_clk);
        trn_rsrc_rdy_n = 1'b1;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
    endtask

    task automatic send_mrd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        send_beat({d0, d1}, 1'b1, 1'b0, 8'h00, 1'b0);
        send_beat({d2, 32'h0}, 1'b0, 1'b1, 8'h0F, 1'b0);
        rx_idle();
    endtask

    task automatic expect_cpl(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        logic [31:0] dws[$];
        int    len;
        int    base;
        int    nbt;
        beat_t b;
        len  = int'(d0[9:0]);
        base = int'(d2 >> 2) % DEPTH;
        dws.push_back({8'h4A, 1'b0, d0[22:20], 4'b0, 2'b0, d0[13:12], 2'b0, d0[9:0]});
        dws.push_back({cfg_bus_number, cfg_device_number, cfg_function_number, 3'b0, 1'b0, 12'(len * 4)});
        dws.push_back({d1[31:16], d1[15:8], 1'b0, d2[6:2], 2'b0});
        for (int i = 0; i < len; i++) dws.push_back(mem[(base + i) % DEPTH]);
        if (dws.size() % 2 != 0) dws.push_back(32'h0);
        nbt = dws.size() / 2;
        for (int k = 0; k < nbt; k++) begin
            b.td  = {dws[2*k], dws[2*k+1]};
            b.sof = (k == 0);
            b.eof = (k == nbt - 1);
            b.rem = (k == nbt - 1 && ((3 + len) % 2 == 1)) ? 8'h0F : 8'h00;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_cpl();
        int n;
        n = 0;
        while (cpl_cnt < exp_cpl && n < 3000) begin
            @(negedge trn_clk);
            n++;
        end
        repeat (2) @(negedge trn_clk);
        chk("cpl_count", cpl_cnt, exp_cpl);
    endtask

    task automatic do_mrd(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        expect_cpl(d0, d1, d2);
        send_mrd(d0, d1, d2);
        exp_cpl++;
        wait_cpl();
    endtask

    task automatic compare_beats(input string tag);
        int n;
        chk({tag, "_nbeats"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_td%0d", tag, i), obs_q[i].td, exp_q[i].td);
            chk($sformatf("%s_flags%0d", tag, i), {obs_q[i].sof, obs_q[i].eof, obs_q[i].rem},
                {exp_q[i].sof, exp_q[i].eof, exp_q[i].rem});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic rst_vals(input string tag);
        chk({tag, "_ctl"}, 64'({trn_rdst_rdy_n, trn_rnp_ok_n, trn_tsof_n, trn_teof_n,
                                trn_tsrc_rdy_n, trn_tsrc_dsc_n, cpl_done, err_drop}), 64'hBC);
        chk({tag, "_td"}, trn_td, 64'h0);
        chk({tag, "_trem"}, trn_trem_n, 8'h00);
        chk({tag, "_adr"}, mem_adr, 0);
    endtask

    task automatic check_dropped(input string tag);
        repeat (20) @(negedge trn_clk);
        chk({tag, "_err"}, err_cnt, exp_err);
        chk({tag, "_notx"}, obs_q.size(), 0);
        chk({tag, "_nocpl"}, cpl_cnt, exp_cpl);
    endtask

    initial begin
        int n;
        logic [31:0] d0, d1, d2;
        trn_reset_n = 1'b0;
        trn_lnk_up_n = 1'b0;
        trn_rd = 64'h0;
        trn_rrem_n = 8'h00;
        trn_rsof_n = 1'b1;
        trn_reof_n = 1'b1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_tbuf_av = 6'd4;
        cfg_bus_number = 8'h18;
        cfg_device_number = 5'd0;
        cfg_function_number = 3'd0;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

        repeat (3) @(negedge trn_clk);
        rst_vals("reset");
        trn_reset_n = 1'b1;
        repeat (2) @(negedge trn_clk);

        // Single-DW read with known header image
        mem[4] = 32'hDEADBEEF;
        do_mrd(32'h00000001, 32'h00002A0F, 32'h00000010);
        chk("t1_beat0", (obs_q.size() > 0) ? obs_q[0].td : 64'h0, 64'h4A000001_18000004);
        chk("t1_beat1", (obs_q.size() > 1) ? obs_q[1].td : 64'h0, 64'h00002A10_DEADBEEF);
        compare_beats("t1");

        // 4-DW read
        for (int i = 0; i < 4; i++) mem[8 + i] = 32'(i + 1);
        do_mrd(32'h00000004, 32'h12345500, 32'h00000020);
        compare_beats("t2");

        // Same with alternating sink backpressure and the link dropping mid-TX
        bp_mode = 1;
        expect_cpl(32'h00000004, 32'h12345500, 32'h00000020);
        send_mrd(32'h00000004, 32'h12345500, 32'h00000020);
        exp_cpl++;
        n = 0;
        while (obs_q.size() == 0 && n < 500) begin
            @(negedge trn_clk);
            n++;
        end
        trn_lnk_up_n = 1'b1;
        wait_cpl();
        chk("lnk_dn_rdy", trn_rdst_rdy_n, 1'b1);
        trn_lnk_up_n = 1'b0;
        bp_mode = 0;
        compare_beats("t3");

        // MWr followed back-to-back by an MRd
        expect_cpl(32'h00000002, 32'hBEEF0700, 32'h00000100);
        send_beat({32'h40000002, 32'h00001100}, 1'b1, 1'b0, 8'h00, 1'b0);
        send_beat({32'h00000040, 32'hAAAA5555}, 1'b0, 1'b0, 8'h00, 1'b0);
        send_beat({32'h12345678, 32'h0}, 1'b0, 1'b1, 8'h0F, 1'b0);
        send_mrd(32'h00000002, 32'hBEEF0700, 32'h00000100);
        exp_cpl++;
        wait_cpl();
        chk("mwr_err", err_cnt, exp_err);
        compare_beats("t4");

        // Length above MAX_DW
        send_mrd(32'h00000011, 32'h00000100, 32'h00000040);
        exp_err++;
        check_dropped("len17");

        // 4DW MRd
        send_beat({32'h20000001, 32'h00000100}, 1'b1, 1'b0, 8'h00, 1'b0);
        send_beat({32'h00000000, 32'h00000040}, 1'b0, 1'b1, 8'h00, 1'b0);
        rx_idle();
        exp_err++;
        check_dropped("mrd4dw");

        // Reset while beat1 of a 4-DW completion is on the bus
        send_mrd(32'h00000004, 32'h00000100, 32'h00000020);
        n = 0;
        while (!(!trn_tsrc_rdy_n && trn_tsof_n) && n < 500) begin
            @(negedge trn_clk);
            n++;
        end
        chk("rst_beat1_seen", n < 500, 1'b1);
        #1 trn_reset_n = 1'b0;
        #1 rst_vals("rst_mid_tx");
        repeat (2) @(negedge trn_clk);
        trn_reset_n = 1'b1;
        obs_q.delete();
        repeat (2) @(negedge trn_clk);
        do_mrd(32'h00000001, 32'h00000500, 32'h00000010);
        compare_beats("t7");

        // Discontinue during the header
        send_beat({32'h00000001, 32'h00000100}, 1'b1, 1'b0, 8'h00, 1'b0);
        send_beat({32'h00000010, 32'h0}, 1'b0, 1'b0, 8'h00, 1'b1);
        rx_idle();
        exp_err++;
        check_dropped("dsc");
        do_mrd(32'h00000003, 32'h00000900, 32'h00000FF8);
        compare_beats("t8");

        // Randomized traffic
        bp_mode = 2;
        for (int it = 0; it < 40; it++) begin
            int kind;
            cfg_bus_number      = 8'($urandom);
            cfg_device_number   = 5'($urandom);
            cfg_function_number = 3'($urandom);
            kind = $urandom_range(0, 7);
            d0 = $urandom;
            d1 = $urandom;
            d2 = $urandom;
            d2[1:0] = 2'b00;
            d0[31:24] = 8'h00;
            if (kind == 0) begin
                send_beat({32'h40000002, d1}, 1'b1, 1'b0, 8'h00, 1'b0);
                send_beat({d2, 32'($urandom)}, 1'b0, 1'b0, 8'h00, 1'b0);
                send_beat({32'($urandom), 32'h0}, 1'b0, 1'b1, 8'h0F, 1'b0);
                rx_idle();
                check_dropped($sformatf("r%0d_mwr", it));
            end else if (kind == 1) begin
                d0[9:0] = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(MAX_DW + 1, 1023));
                send_mrd(d0, d1, d2);
                exp_err++;
                check_dropped($sformatf("r%0d_bad", it));
            end else begin
                d0[9:0] = 10'($urandom_range(1, MAX_DW));
                expect_cpl(d0, d1, d2);
                if ($urandom_range(0, 2) == 0) begin
                    trn_tbuf_av = 6'd0;
                    send_mrd(d0, d1, d2);
                    repeat (30) @(negedge trn_clk);
                    chk($sformatf("r%0d_tbuf_gate", it), obs_q.size(), 0);
                    trn_tbuf_av = 6'($urandom_range(1, 63));
                end else begin
                    send_mrd(d0, d1, d2);
                end
                exp_cpl++;
                wait_cpl();
                compare_beats($sformatf("r%0d", it));
            end
        end
        bp_mode = 0;
        repeat (5) @(negedge trn_clk);
        chk("total_err", err_cnt, exp_err);
        chk("total_cpl", cpl_cnt, exp_cpl);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
